accel_job_sequencer: RTL and testbench
======================================

// Module: accel_job_sequencer
// PURPOSE
//  Parametrised job sequencer for the systolic accelerator; successor to the single-job matrix/conv controller.
//  Arbitrates NUM_OPS operation-request channels round-robin and latches the granted descriptor.
//  Drives the AXI read, systolic compute and AXI write engines through start-pulse/done handshakes.
//  Adds per-phase watchdog, abort, descriptor validation, error reporting and a completed-job counter.
// PARAMETERS
//  NUM_OPS     2      number of request channels (ch0 = matrix, ch1 = convolution; max 8)
//  ADDR_W      32     address width
//  DIM_W       4      dimension field width
//  TIMEOUT     1024   max cycles allowed per phase before timeout error (>=2)
//  CNT_W       16     completed-job counter width
// PORTS
//  M_AXI_ACLK      in   1                 clock, all logic rising-edge
//  M_AXI_ARESET    in   1                 synchronous reset, active-high
//  op_req          in   NUM_OPS           level request per channel
//  op_src_a_addr   in   NUM_OPS*ADDR_W    per-channel operand A / kernel address (ch i at [i*ADDR_W +: ADDR_W])
//  op_dim_a        in   NUM_OPS*DIM_W     per-channel A dimension
//  op_src_b_addr   in   NUM_OPS*ADDR_W    per-channel operand B / image address
//  op_dim_b        in   NUM_OPS*DIM_W     per-channel B dimension
//  op_dst_addr     in   NUM_OPS*ADDR_W    per-channel result address
//  op_ack          out  NUM_OPS           1-cycle grant pulse to the accepted channel
//  abort           in   1                 abort current job
//  rd_done/cmp_done/wr_done in 1          engine completion pulses
//  rd_start/cmp_start/wr_start out 1      1-cycle engine start pulses
//  job_addr_a, job_addr_b, job_addr_dst out ADDR_W   latched descriptor
//  job_dim_a, job_dim_b  out  DIM_W       latched dimensions
//  job_op          out  $clog2(NUM_OPS) (min 1)  latched channel index (0 = matrix)
//  busy            out  1                 high in every state except IDLE
//  job_done        out  1                 1-cycle pulse on successful completion
//  job_err         out  1                 1-cycle pulse on error
//  err_code        out  3                 0 none, 1 bad dim, 2 rd timeout, 3 cmp timeout, 4 wr timeout, 5 abort
//  jobs_completed  out  CNT_W             successful-job count, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all pulses, busy, op_ack = 0; job_* = 0; err_code = 0; jobs_completed = 0; rr pointer = NUM_OPS-1 (ch0 first).
//  States: IDLE, RD, CMP, WR, DONE, ERR.
//  IDLE, cycle T, any op_req: grant first set bit searching from ptr+1 modulo NUM_OPS.
//    At T: op_ack[g] = 1. Latch descriptor and job_op; ptr <= g.
//    If op_dim_a[g] == 0 or op_dim_b[g] == 0: go to ERR with err_code 1. No engine is started.
//    Otherwise go to RD; rd_start = 1 in cycle T+1 only.
//  RD: rd_done -> CMP with cmp_start pulse on CMP entry cycle. CMP: cmp_done -> WR with wr_start pulse.
//    WR: wr_done -> DONE.
//  Done pulses are sampled only in their own phase state; a done pulse arriving in any other state is ignored.
//  Watchdog: counter clears on each phase entry and increments every cycle in RD/CMP/WR.
//    Count == TIMEOUT-1 with no done -> ERR, err_code 2/3/4.
//    Done in the same cycle as the timeout: done wins.
//  abort in RD/CMP/WR/DONE -> ERR with err_code 5; abort outranks done and timeout in that cycle. abort in IDLE/ERR is ignored.
//  DONE (1 cycle): job_done = 1; jobs_completed += 1, holding at all-ones; err_code <= 0; then IDLE.
//  ERR (1 cycle): job_err = 1; err_code holds until the next job's DONE or ERR; then IDLE.
//  New requests are sampled only in IDLE, so minimum job latency is 5 cycles (IDLE→RD→CMP→WR→DONE with same-cycle dones).
//  Descriptor outputs are stable from the grant until the next grant; input descriptor changes mid-job have no effect.
//  Reset mid-job: immediate return to reset values; no pulses emitted that cycle.
// TESTING
//  1 ch0 req, dims 4/4, rd/cmp/wr_done each 3 cycles after start
//    -> op_ack[0], rd_start at T+1, job_done once, jobs_completed=1, err_code=0.
//  2 op_req=2'b11 held for 3 jobs -> grant order ch0, ch1, ch0; job_op follows; descriptors match the granted channel.
//  3 ch1 req with op_dim_b=0 -> op_ack[1], job_err next cycle, err_code=1, no rd_start.
//  4 TIMEOUT=16, cmp_done withheld -> job_err 16 cycles after CMP entry, err_code=3, wr_start never pulses.
//  5 abort coincident with wr_done -> err_code=5, no job_done, jobs_completed unchanged.
//  6 CNT_W=2, run 5 good jobs -> jobs_completed saturates at 3; reset mid-CMP -> busy=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/accel_job_sequencer.sv
// Round-robin job sequencer for the systolic accelerator: grants one request channel,
// then walks the read / compute / write engines with a per-phase watchdog and error reporting.
module accel_job_sequencer #(
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  localparam int OP_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,
  input  logic [NUM_OPS-1:0]        op_req,
  input  logic [NUM_OPS*ADDR_W-1:0] op_src_a_addr,
  input  logic [NUM_OPS*DIM_W-1:0]  op_dim_a,
  input  logic [NUM_OPS*ADDR_W-1:0] op_src_b_addr,
  input  logic [NUM_OPS*DIM_W-1:0]  op_dim_b,
  input  logic [NUM_OPS*ADDR_W-1:0] op_dst_addr,
  output logic [NUM_OPS-1:0]        op_ack,
  input  logic                      abort,
  input  logic                      rd_done,
  input  logic                      cmp_done,
  input  logic                      wr_done,
  output logic                      rd_start,
  output logic                      cmp_start,
  output logic                      wr_start,
  output logic [ADDR_W-1:0]         job_addr_a,
  output logic [ADDR_W-1:0]         job_addr_b,
  output logic [ADDR_W-1:0]         job_addr_dst,
  output logic [DIM_W-1:0]          job_dim_a,
  output logic [DIM_W-1:0]          job_dim_b,
  output logic [OP_W-1:0]           job_op,
  output logic                      busy,
  output logic                      job_done,
  output logic                      job_err,
  output logic [2:0]                err_code,
  output logic [CNT_W-1:0]          jobs_completed
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_DIM     = 3'd1;
  localparam logic [2:0] ERR_RD_TMO  = 3'd2;
  localparam logic [2:0] ERR_CMP_TMO = 3'd3;
  localparam logic [2:0] ERR_WR_TMO  = 3'd4;
  localparam logic [2:0] ERR_ABORT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [OP_W-1:0]   rr_ptr;
  logic [WD_W-1:0]   wd_cnt;

  logic [ADDR_W-1:0] ch_addr_a   [NUM_OPS];
  logic [ADDR_W-1:0] ch_addr_b   [NUM_OPS];
  logic [ADDR_W-1:0] ch_addr_dst [NUM_OPS];
  logic [DIM_W-1:0]  ch_dim_a    [NUM_OPS];
  logic [DIM_W-1:0]  ch_dim_b    [NUM_OPS];

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_unpack
    assign ch_addr_a[i]   = op_src_a_addr[i*ADDR_W +: ADDR_W];
    assign ch_addr_b[i]   = op_src_b_addr[i*ADDR_W +: ADDR_W];
    assign ch_addr_dst[i] = op_dst_addr[i*ADDR_W +: ADDR_W];
    assign ch_dim_a[i]    = op_dim_a[i*DIM_W +: DIM_W];
    assign ch_dim_b[i]    = op_dim_b[i*DIM_W +: DIM_W];
  end

  // Search starts one past the last granted channel so every requester gets a turn.
  logic            gnt_valid;
  logic [OP_W-1:0] gnt_idx;
  logic [OP_W-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_OPS; i++) begin
      cand = (cand == OP_W'(NUM_OPS - 1)) ? '0 : cand + OP_W'(1);
      if (!gnt_valid && op_req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    op_ack = '0;
    if (!M_AXI_ARESET && state == S_IDLE && gnt_valid) begin
      op_ack[gnt_idx] = 1'b1;
    end
  end

  logic       phase_done;
  logic [2:0] tmo_code;

  always_comb begin
    phase_done = 1'b0;
    tmo_code   = ERR_NONE;
    case (state)
      S_RD:    begin phase_done = rd_done;  tmo_code = ERR_RD_TMO;  end
      S_CMP:   begin phase_done = cmp_done; tmo_code = ERR_CMP_TMO; end
      S_WR:    begin phase_done = wr_done;  tmo_code = ERR_WR_TMO;  end
      default: ;
    endcase
  end

  logic dim_bad;
  assign dim_bad = (ch_dim_a[gnt_idx] == '0) || (ch_dim_b[gnt_idx] == '0);

  // Priority inside a phase: abort, then done, then watchdog expiry.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state          <= S_IDLE;
      rr_ptr         <= OP_W'(NUM_OPS - 1);
      wd_cnt         <= '0;
      rd_start       <= 1'b0;
      cmp_start      <= 1'b0;
      wr_start       <= 1'b0;
      job_addr_a     <= '0;
      job_addr_b     <= '0;
      job_addr_dst   <= '0;
      job_dim_a      <= '0;
      job_dim_b      <= '0;
      job_op         <= '0;
      busy           <= 1'b0;
      job_done       <= 1'b0;
      job_err        <= 1'b0;
      err_code       <= ERR_NONE;
      jobs_completed <= '0;
    end else begin
      rd_start  <= 1'b0;
      cmp_start <= 1'b0;
      wr_start  <= 1'b0;
      job_done  <= 1'b0;
      job_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            rr_ptr       <= gnt_idx;
            job_addr_a   <= ch_addr_a[gnt_idx];
            job_addr_b   <= ch_addr_b[gnt_idx];
            job_addr_dst <= ch_addr_dst[gnt_idx];
            job_dim_a    <= ch_dim_a[gnt_idx];
            job_dim_b    <= ch_dim_b[gnt_idx];
            job_op       <= gnt_idx;
            busy         <= 1'b1;
            wd_cnt       <= '0;
            if (dim_bad) begin
              state    <= S_ERR;
              job_err  <= 1'b1;
              err_code <= ERR_DIM;
            end else begin
              state    <= S_RD;
              rd_start <= 1'b1;
            end
          end
        end
        S_RD, S_CMP, S_WR: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (abort) begin
            state    <= S_ERR;
            job_err  <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (phase_done) begin
            wd_cnt <= '0;
            case (state)
              S_RD:    begin state <= S_CMP;  cmp_start <= 1'b1; end
              S_CMP:   begin state <= S_WR;   wr_start  <= 1'b1; end
              default: begin state <= S_DONE; job_done  <= 1'b1; end
            endcase
          end else if (wd_cnt == WD_MAX) begin
            state    <= S_ERR;
            job_err  <= 1'b1;
            err_code <= tmo_code;
          end
        end
        S_DONE: begin
          if (abort) begin
            state    <= S_ERR;
            job_err  <= 1'b1;
            err_code <= ERR_ABORT;
          end else begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            err_code <= ERR_NONE;
            if (jobs_completed != {CNT_W{1'b1}}) begin
              jobs_completed <= jobs_completed + CNT_W'(1);
            end
          end
        end
        S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Bench for accel_job_sequencer: a job-level model predicts every output each cycle,
// backed by literal latency, grant-order and error-code expectations.
module tb_accel_job_sequencer;

  localparam int NUM_OPS = 2;
  localparam int ADDR_W  = 32;
  localparam int DIM_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;

  logic                      M_AXI_ACLK;
  logic                      M_AXI_ARESET;
  logic [NUM_OPS-1:0]        op_req;
  logic [NUM_OPS*ADDR_W-1:0] op_src_a_addr;
  logic [NUM_OPS*DIM_W-1:0]  op_dim_a;
  logic [NUM_OPS*ADDR_W-1:0] op_src_b_addr;
  logic [NUM_OPS*DIM_W-1:0]  op_dim_b;
  logic [NUM_OPS*ADDR_W-1:0] op_dst_addr;
  logic [NUM_OPS-1:0]        op_ack;
  logic                      abort;
  logic                      rd_done;
  logic                      cmp_done;
  logic                      wr_done;
  logic                      rd_start;
  logic                      cmp_start;
  logic                      wr_start;
  logic [ADDR_W-1:0]         job_addr_a;
  logic [ADDR_W-1:0]         job_addr_b;
  logic [ADDR_W-1:0]         job_addr_dst;
  logic [DIM_W-1:0]          job_dim_a;
  logic [DIM_W-1:0]          job_dim_b;
  logic                      job_op;
  logic                      busy;
  logic                      job_done;
  logic                      job_err;
  logic [2:0]                err_code;
  logic [CNT_W-1:0]          jobs_completed;

  accel_job_sequencer #(
    .NUM_OPS (NUM_OPS),
    .ADDR_W  (ADDR_W),
    .DIM_W   (DIM_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .M_AXI_ACLK     (M_AXI_ACLK),
    .M_AXI_ARESET   (M_AXI_ARESET),
    .op_req         (op_req),
    .op_src_a_addr  (op_src_a_addr),
    .op_dim_a       (op_dim_a),
    .op_src_b_addr  (op_src_b_addr),
    .op_dim_b       (op_dim_b),
    .op_dst_addr    (op_dst_addr),
    .op_ack         (op_ack),
    .abort          (abort),
    .rd_done        (rd_done),
    .cmp_done       (cmp_done),
    .wr_done        (wr_done),
    .rd_start       (rd_start),
    .cmp_start      (cmp_start),
    .wr_start       (wr_start),
    .job_addr_a     (job_addr_a),
    .job_addr_b     (job_addr_b),
    .job_addr_dst   (job_addr_dst),
    .job_dim_a      (job_dim_a),
    .job_dim_b      (job_dim_b),
    .job_op         (job_op),
    .busy           (busy),
    .job_done       (job_done),
    .job_err        (job_err),
    .err_code       (err_code),
    .jobs_completed (jobs_completed)
  );

  initial M_AXI_ACLK = 1'b0;
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  logic [ADDR_W-1:0] ch_a   [NUM_OPS];
  logic [ADDR_W-1:0] ch_b   [NUM_OPS];
  logic [ADDR_W-1:0] ch_dst [NUM_OPS];
  logic [DIM_W-1:0]  ch_dima [NUM_OPS];
  logic [DIM_W-1:0]  ch_dimb [NUM_OPS];

  assign op_src_a_addr = {ch_a[1], ch_a[0]};
  assign op_src_b_addr = {ch_b[1], ch_b[0]};
  assign op_dst_addr   = {ch_dst[1], ch_dst[0]};
  assign op_dim_a      = {ch_dima[1], ch_dima[0]};
  assign op_dim_b      = {ch_dimb[1], ch_dimb[0]};

  // Model of what every output must be in the current cycle.
  logic [1:0]        exp_ack;
  logic              exp_rd_start, exp_cmp_start, exp_wr_start;
  logic              exp_busy, exp_done, exp_err;
  logic [ADDR_W-1:0] exp_a, exp_b, exp_dst;
  logic [DIM_W-1:0]  exp_dima, exp_dimb;
  logic              exp_op;
  logic [2:0]        exp_code;
  logic [CNT_W-1:0]  exp_jobs;
  logic              m_ptr;
  bit                pend_done;
  bit                chk_en;

  int n_chk;
  int n_err;
  int cyc;
  int t_ack, t_rd, t_cmp, t_err, t_done;
  int cnt_rd, cnt_wr;
  logic [1:0] gnt_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge M_AXI_ACLK) cyc++;

  always @(negedge M_AXI_ACLK) begin
    if (chk_en) begin
      checkOutput("op_ack",         32'(op_ack),         32'(exp_ack));
      checkOutput("rd_start",       32'(rd_start),       32'(exp_rd_start));
      checkOutput("cmp_start",      32'(cmp_start),      32'(exp_cmp_start));
      checkOutput("wr_start",       32'(wr_start),       32'(exp_wr_start));
      checkOutput("busy",           32'(busy),           32'(exp_busy));
      checkOutput("job_done",       32'(job_done),       32'(exp_done));
      checkOutput("job_err",        32'(job_err),        32'(exp_err));
      checkOutput("err_code",       32'(err_code),       32'(exp_code));
      checkOutput("jobs_completed", 32'(jobs_completed), 32'(exp_jobs));
      checkOutput("job_addr_a",     job_addr_a,          exp_a);
      checkOutput("job_addr_b",     job_addr_b,          exp_b);
      checkOutput("job_addr_dst",   job_addr_dst,        exp_dst);
      checkOutput("job_dim_a",      32'(job_dim_a),      32'(exp_dima));
      checkOutput("job_dim_b",      32'(job_dim_b),      32'(exp_dimb));
      checkOutput("job_op",         32'(job_op),         32'(exp_op));
      if (op_ack != 2'b00) begin
        t_ack = cyc;
        gnt_q.push_back(op_ack);
      end
      if (rd_start)  begin t_rd = cyc; cnt_rd++; end
      if (cmp_start) t_cmp = cyc;
      if (wr_start)  cnt_wr++;
      if (job_err)   t_err = cyc;
      if (job_done)  t_done = cyc;
    end
  end

  task automatic modelReset();
    m_ptr     = 1'b1;
    exp_a     = '0;
    exp_b     = '0;
    exp_dst   = '0;
    exp_dima  = '0;
    exp_dimb  = '0;
    exp_op    = 1'b0;
    exp_code  = 3'd0;
    exp_jobs  = '0;
    pend_done = 1'b0;
  endtask

  // Advance one cycle; pulses default low and a finished job's bookkeeping lands now.
  task automatic stepCycle();
    @(posedge M_AXI_ACLK);
    #1;
    rd_done       = 1'b0;
    cmp_done      = 1'b0;
    wr_done       = 1'b0;
    abort         = 1'b0;
    exp_ack       = 2'b00;
    exp_rd_start  = 1'b0;
    exp_cmp_start = 1'b0;
    exp_wr_start  = 1'b0;
    exp_done      = 1'b0;
    exp_err       = 1'b0;
    exp_busy      = 1'b0;
    if (pend_done) begin
      pend_done = 1'b0;
      exp_code  = 3'd0;
      if (exp_jobs != {CNT_W{1'b1}}) exp_jobs = exp_jobs + 1'b1;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // One job from its IDLE request cycle to its DONE/ERR cycle. Delays are cycles after each
  // phase's start (-1 withholds the done); ab_*/rs_* place an abort or a reset in a phase.
  task automatic applyStimulus(input logic [1:0] req, input bit hold,
                               input int d_rd, input int d_cmp, input int d_wr,
                               input int ab_ph, input int ab_off,
                               input int rs_ph, input int rs_off);
    int   dly [4];
    int   k;
    int   code;
    bit   adv;
    logic g;
    dly[0] = 0;
    dly[1] = d_rd;
    dly[2] = d_cmp;
    dly[3] = d_wr;
    stepCycle();
    op_req = req;
    g = req[~m_ptr] ? ~m_ptr : m_ptr;
    exp_ack[g] = 1'b1;
    stepCycle();
    m_ptr    = g;
    exp_a    = ch_a[g];
    exp_b    = ch_b[g];
    exp_dst  = ch_dst[g];
    exp_dima = ch_dima[g];
    exp_dimb = ch_dimb[g];
    exp_op   = g;
    ch_dst[g] = ch_dst[g] + 32'h100;
    exp_busy = 1'b1;
    if (exp_dima == '0 || exp_dimb == '0) begin
      exp_err  = 1'b1;
      exp_code = 3'd1;
      if (!hold) op_req = 2'b00;
      return;
    end
    for (int p = 1; p <= 3; p++) begin
      code = 0;
      adv  = 1'b0;
      k    = 0;
      while (!adv && code == 0) begin
        if (k > 0) stepCycle();
        exp_busy = 1'b1;
        if (k == 0) begin
          case (p)
            1:       exp_rd_start  = 1'b1;
            2:       exp_cmp_start = 1'b1;
            default: exp_wr_start  = 1'b1;
          endcase
        end
        if (dly[p] == k) begin
          case (p)
            1:       rd_done  = 1'b1;
            2:       cmp_done = 1'b1;
            default: wr_done  = 1'b1;
          endcase
        end
        if (ab_ph == p && ab_off == k) abort = 1'b1;
        if (rs_ph == p && rs_off == k) begin
          M_AXI_ARESET = 1'b1;
          stepCycle();
          M_AXI_ARESET = 1'b0;
          op_req = 2'b00;
          modelReset();
          return;
        end
        if (abort) code = 5;
        else if (dly[p] == k) adv = 1'b1;
        else if (k == TIMEOUT - 1) code = p + 1;
        k++;
      end
      stepCycle();
      exp_busy = 1'b1;
      if (code != 0) begin
        exp_err  = 1'b1;
        exp_code = 3'(code);
        if (!hold) op_req = 2'b00;
        return;
      end
    end
    exp_done  = 1'b1;
    pend_done = 1'b1;
    if (!hold) op_req = 2'b00;
  endtask

  int w0;
  int r0;

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    cnt_rd = 0;
    cnt_wr = 0;
    t_ack = 0; t_rd = 0; t_cmp = 0; t_err = 0; t_done = 0;
    chk_en = 1'b0;
    M_AXI_ARESET = 1'b1;
    op_req = 2'b00;
    abort = 1'b0;
    rd_done = 1'b0;
    cmp_done = 1'b0;
    wr_done = 1'b0;
    ch_a[0] = 32'h1000_0000; ch_b[0] = 32'h2000_0000; ch_dst[0] = 32'h3000_0000;
    ch_a[1] = 32'h4000_0040; ch_b[1] = 32'h5000_0050; ch_dst[1] = 32'h6000_0060;
    ch_dima[0] = 4'd4; ch_dimb[0] = 4'd4;
    ch_dima[1] = 4'd3; ch_dimb[1] = 4'd7;
    exp_ack = 2'b00;
    exp_rd_start = 1'b0; exp_cmp_start = 1'b0; exp_wr_start = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    modelReset();

    @(posedge M_AXI_ACLK);
    #1;
    chk_en = 1'b1;
    stepCycle();
    M_AXI_ARESET = 1'b0;
    checkOutput("reset_jobs", 32'(jobs_completed), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Stray dones and abort while idle must be ignored.
    stepCycle();
    rd_done = 1'b1; cmp_done = 1'b1; wr_done = 1'b1; abort = 1'b1;
    idleCycles(2);

    $display("[TB] test 1: single matrix job");
    applyStimulus(2'b01, 1'b0, 3, 3, 3, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("t1_rd_start_latency", 32'(t_rd - t_ack), 32'd1);
    checkOutput("t1_done_latency", 32'(t_done - t_ack), 32'd13);
    checkOutput("t1_jobs", 32'(jobs_completed), 32'd1);
    checkOutput("t1_err_code", 32'(err_code), 32'd0);

    $display("[TB] test 3: zero dimension on ch1");
    ch_dimb[1] = 4'd0;
    r0 = cnt_rd;
    applyStimulus(2'b10, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("t3_err_latency", 32'(t_err - t_ack), 32'd1);
    checkOutput("t3_err_code", 32'(err_code), 32'd1);
    checkOutput("t3_no_rd_start", 32'(cnt_rd - r0), 32'd0);
    ch_dimb[1] = 4'd7;

    $display("[TB] test 5: abort with wr_done");
    applyStimulus(2'b10, 1'b0, 1, 1, 2, 3, 2, 0, 0);
    idleCycles(2);
    checkOutput("t5_err_code", 32'(err_code), 32'd5);
    checkOutput("t5_jobs", 32'(jobs_completed), 32'd1);

    $display("[TB] test 2: held requests on both channels");
    gnt_q.delete();
    applyStimulus(2'b11, 1'b1, 1, 2, 0, 0, 0, 0, 0);
    applyStimulus(2'b11, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(2'b11, 1'b0, 2, 1, 1, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("t2_grants", 32'(gnt_q.size()), 32'd3);
    if (gnt_q.size() == 3) begin
      checkOutput("t2_grant0", 32'(gnt_q[0]), 32'd1);
      checkOutput("t2_grant1", 32'(gnt_q[1]), 32'd2);
      checkOutput("t2_grant2", 32'(gnt_q[2]), 32'd1);
    end
    checkOutput("t2_jobs_sat", 32'(jobs_completed), 32'd3);

    $display("[TB] test 4: compute watchdog");
    applyStimulus(2'b01, 1'b0, TIMEOUT - 1, 0, 0, 0, 0, 0, 0);
    idleCycles(1);
    w0 = cnt_wr;
    applyStimulus(2'b01, 1'b0, 2, -1, 0, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("t4_timeout_latency", 32'(t_err - t_cmp), 32'd16);
    checkOutput("t4_err_code", 32'(err_code), 32'd3);
    checkOutput("t4_no_wr_start", 32'(cnt_wr - w0), 32'd0);

    $display("[TB] test 6: saturation and reset mid-job");
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 0, 1, 0, 0, 0, 0, 0);
      idleCycles(1);
    end
    checkOutput("t6_jobs_sat", 32'(jobs_completed), 32'd3);
    applyStimulus(2'b10, 1'b0, 1, -1, 0, 0, 0, 2, 2);
    checkOutput("t6_busy_after_reset", 32'(busy), 32'd0);
    checkOutput("t6_jobs_after_reset", 32'(jobs_completed), 32'd0);
    checkOutput("t6_op_after_reset", 32'(job_op), 32'd0);
    idleCycles(1);
    applyStimulus(2'b11, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);
    checkOutput("t6_first_grant_ch0", 32'(gnt_q[$]), 32'd1);
    checkOutput("t6_jobs_one", 32'(jobs_completed), 32'd1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
